// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW hazard detection and ID-stage forwarding control
// for the 5-stage MIPS pipeline, with a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_id_instr,
  input  logic             fwd_en,
  output logic             ex_forward_a,
  output logic             ex_forward_b,
  output logic             mem_forward_a,
  output logic             mem_forward_b,
  output logic             stall,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic       wr;
    logic [4:0] dest;
    logic       ld;
  } tag_t;

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_shamt;

  assign op           = if_id_instr[31:26];
  assign rs           = if_id_instr[25:21];
  assign rt           = if_id_instr[20:16];
  assign rd           = if_id_instr[15:11];
  assign funct        = if_id_instr[5:0];
  assign unused_shamt = ^if_id_instr[10:6];

  logic rd_a;
  logic rd_b;
  tag_t dec_tag;

  always_comb begin
    rd_a    = 1'b0;
    rd_b    = 1'b0;
    dec_tag = '0;
    unique case (1'b1)
      (op == 6'h00 && funct != 6'h08): begin
        rd_a         = 1'b1;
        rd_b         = 1'b1;
        dec_tag.wr   = 1'b1;
        dec_tag.dest = rd;
      end
      (op == 6'h00 && funct == 6'h08): begin
        rd_a = 1'b1;
      end
      (op == 6'h08): begin
        rd_a         = 1'b1;
        dec_tag.wr   = 1'b1;
        dec_tag.dest = rt;
      end
      (op == 6'h23): begin
        rd_a         = 1'b1;
        dec_tag.wr   = 1'b1;
        dec_tag.dest = rt;
        dec_tag.ld   = 1'b1;
      end
      (op == 6'h2B || op == 6'h04 || op == 6'h05): begin
        rd_a = 1'b1;
        rd_b = 1'b1;
      end
      default: begin
        rd_a = 1'b0;
      end
    endcase
    // $0 is hardwired, so a write to it never creates a hazard
    if (dec_tag.dest == 5'd0) begin
      dec_tag = '0;
    end
  end

  tag_t             ex_q;
  tag_t             ex_d;
  tag_t             mem_q;
  tag_t             mem_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic ex_hit_a;
  logic ex_hit_b;
  logic mem_hit_a;
  logic mem_hit_b;

  assign ex_hit_a  = ex_q.wr && ex_q.dest == rs && rd_a;
  assign ex_hit_b  = ex_q.wr && ex_q.dest == rt && rd_b;
  assign mem_hit_a = mem_q.wr && mem_q.dest == rs && rd_a;
  assign mem_hit_b = mem_q.wr && mem_q.dest == rt && rd_b;

  always_comb begin
    ex_forward_a  = 1'b0;
    ex_forward_b  = 1'b0;
    mem_forward_a = 1'b0;
    mem_forward_b = 1'b0;
    stall         = 1'b0;
    if (fwd_en) begin
      ex_forward_a  = ex_hit_a && !ex_q.ld;
      ex_forward_b  = ex_hit_b && !ex_q.ld;
      mem_forward_a = mem_hit_a && !ex_hit_a;
      mem_forward_b = mem_hit_b && !ex_hit_b;
      stall         = (ex_hit_a || ex_hit_b) && ex_q.ld;
    end else begin
      stall = ex_hit_a || ex_hit_b || mem_hit_a || mem_hit_b;
    end
  end

  assign id_ex_bubble = stall;
  assign stall_count  = cnt_q;

  always_comb begin
    ex_d  = stall ? tag_t'('0) : dec_tag;
    mem_d = ex_q;
    cnt_d = cnt_q;
    if (stall && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
